// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
//   Shared definitions for the PLL lock sequencer: FSM state encodings,
//   default timing constants (27 MHz reference), field widths and a
//   saturating-increment helper for the lock-loss counter.
package pll_seq_pkg;

  // Encodings are visible on state_o, so keep them fixed.
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } seq_state_t;

  // Default timing at 27 MHz
  localparam int DEF_RST_CYCLES    = 27;     // 1 us of PLL reset
  localparam int DEF_LOCK_TIMEOUT  = 27000;  // 1 ms to lock
  localparam int DEF_STABLE_CYCLES = 2700;   // 100 us of steady lock
  localparam int DEF_MAX_RETRIES   = 3;

  localparam int CNT_W   = 16;
  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
    return (v == {LOSS_W{1'b1}}) ? v : v + LOSS_W'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for slow, level-type status bits crossing into
//   the clk domain. Each bit is synchronized independently, so a multi-bit
//   bus must only carry unrelated flags, never an encoded value.
// Ports
//   clk    destination clock
//   reset  synchronous active-high reset, clears both stages
//   d      asynchronous input bits
//   q      synchronized output bits (2 cycles of latency)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Drives the PLL reset pin, waits for lock, demands a stable lock
//   interval before declaring the output clock ready, retries on lock
//   timeout and latches a failure after MAX_RETRIES+1 unsuccessful
//   attempts. A lock drop while running forces a full re-lock.
// Ports
//   clk27mhz       27 MHz reference clock (sole clock)
//   reset          synchronous active-high reset
//   clk_locked     PLL lock indication, asynchronous
//   restart_req    single-cycle request for a full re-lock
//   pll_reset      PLL reset pin drive (high in PLL_RST and FAIL)
//   clk_ready      registered, high only in RUN
//   pll_fail       high in FAIL; cleared by reset or restart_req
//   lock_loss_cnt  saturating count of lock drops seen in RUN
//   state_o        current FSM state, for debug
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic              clk27mhz,
  input  logic              reset,
  input  logic              clk_locked,
  input  logic              restart_req,
  output logic              pll_reset,
  output logic              clk_ready,
  output logic              pll_fail,
  output logic [LOSS_W-1:0] lock_loss_cnt,
  output logic [2:0]        state_o
);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  logic lock_s;

  seq_state_t         state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [RETRY_W-1:0] retry_cnt, retry_n;
  logic [LOSS_W-1:0]  loss_n;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk27mhz),
    .reset (reset),
    .d     (clk_locked),
    .q     (lock_s)
  );

  // Next-state logic. Every terminal compare is an equality on the state's
  // own limit and the counter is cleared on every transition, so the
  // counter cannot wrap inside any state.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    retry_n = retry_cnt;
    loss_n  = lock_loss_cnt;

    // A drop in RUN is counted even when a restart wins the same cycle.
    if (state == RUN && !lock_s)
      loss_n = sat_inc(lock_loss_cnt);

    if (restart_req) begin
      state_n = PLL_RST;
      cnt_n   = '0;
      retry_n = '0;
    end else begin
      unique case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          // Lock seen on the last allowed cycle still counts as success.
          if (lock_s) begin
            state_n = STABLE;
            cnt_n   = '0;
          end else if (cnt == LOCK_LAST) begin
            cnt_n = '0;
            if (retry_cnt == RETRY_MAX) begin
              state_n = FAIL;
            end else begin
              state_n = PLL_RST;
              retry_n = retry_cnt + RETRY_W'(1);
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        STABLE: begin
          // A glitch restarts the wait for lock but is not a failed attempt.
          if (!lock_s) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_n = RUN;
            cnt_n   = '0;
            retry_n = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        RUN: begin
          cnt_n = '0;
          if (!lock_s)
            state_n = PLL_RST;
        end
        FAIL: begin
          cnt_n = '0;
        end
        default: begin
          state_n = PLL_RST;
          cnt_n   = '0;
          retry_n = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state, so each flop equals a
  // decode of the current state and clk_ready has no combinational path
  // back to clk_locked.
  always_ff @(posedge clk27mhz) begin
    if (reset) begin
      state         <= PLL_RST;
      cnt           <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_reset     <= 1'b1;
      clk_ready     <= 1'b0;
      pll_fail      <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      retry_cnt     <= retry_n;
      lock_loss_cnt <= loss_n;
      pll_reset     <= (state_n == PLL_RST) || (state_n == FAIL);
      clk_ready     <= (state_n == RUN);
      pll_fail      <= (state_n == FAIL);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
//   Directed bench. Stimulus pushes time-stamped expected values into a
//   scoreboard queue; a monitor on the falling edge pops every entry due
//   in that cycle and compares it with the DUT outputs.
module tb_pll_lock_sequencer;

  localparam int SEL_PR   = 0;
  localparam int SEL_RDY  = 1;
  localparam int SEL_FAIL = 2;
  localparam int SEL_LOSS = 3;
  localparam int SEL_ST   = 4;

  logic       clk27mhz = 1'b0;
  logic       reset;
  logic       clk_locked;
  logic       restart_req;
  logic       pll_reset;
  logic       clk_ready;
  logic       pll_fail;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_o;

  pll_lock_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .clk27mhz      (clk27mhz),
    .reset         (reset),
    .clk_locked    (clk_locked),
    .restart_req   (restart_req),
    .pll_reset     (pll_reset),
    .clk_ready     (clk_ready),
    .pll_fail      (pll_fail),
    .lock_loss_cnt (lock_loss_cnt),
    .state_o       (state_o)
  );

  always #5 clk27mhz = ~clk27mhz;

  int unsigned cyc = 0;
  always @(posedge clk27mhz) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    int          sel;
    int unsigned exp;
    string       name;
  } chk_t;

  chk_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic int unsigned observe(input int sel);
    case (sel)
      SEL_PR:   return {31'd0, pll_reset};
      SEL_RDY:  return {31'd0, clk_ready};
      SEL_FAIL: return {31'd0, pll_fail};
      SEL_LOSS: return {24'd0, lock_loss_cnt};
      default:  return {29'd0, state_o};
    endcase
  endfunction

  // d = cycles after the most recent rising edge
  task automatic exp_at(input int unsigned d, input int sel,
                        input int unsigned exp, input string name);
    chk_t c;
    c.cyc  = cyc + d;
    c.sel  = sel;
    c.exp  = exp;
    c.name = name;
    sbq.push_back(c);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk27mhz);
    #1;
  endtask

  // Monitor: compare every entry that has come due.
  always @(negedge clk27mhz) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= cyc) begin
        int unsigned got;
        got = observe(sbq[i].sel);
        vectors++;
        if (got != sbq[i].exp) begin
          miscompares++;
          $display("FAIL %s @cyc %0d: got %0d expected %0d",
                   sbq[i].name, cyc, got, sbq[i].exp);
        end
        sbq.delete(i);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    clk_locked  = 1'b0;
    restart_req = 1'b0;
    step(3);

    // Reset state
    exp_at(0, SEL_PR,   1, "reset_pll_reset");
    exp_at(0, SEL_RDY,  0, "reset_clk_ready");
    exp_at(0, SEL_FAIL, 0, "reset_pll_fail");
    exp_at(0, SEL_LOSS, 0, "reset_loss");
    exp_at(0, SEL_ST,   0, "reset_state");
    reset = 1'b0;

    // First lock: 4-cycle reset pulse, lock 10 cycles after release,
    // ready 2+8+1 cycles after the rise.
    for (int d = 0; d < 4; d++) exp_at(d, SEL_PR, 1, "first_pulse_hi");
    exp_at(4, SEL_PR, 0, "first_pulse_lo");
    exp_at(4, SEL_ST, 1, "first_wait_lock");
    step(14);
    clk_locked = 1'b1;
    exp_at(2,  SEL_ST,   1, "lock_sync_delay");
    exp_at(3,  SEL_ST,   2, "lock_to_stable");
    exp_at(10, SEL_RDY,  0, "ready_not_early");
    exp_at(11, SEL_RDY,  1, "ready_on_time");
    exp_at(11, SEL_ST,   3, "run_state");
    exp_at(11, SEL_FAIL, 0, "no_fail_after_lock");
    step(11);

    // 300 lock drops in RUN, each re-locking; counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      clk_locked = 1'b0;
      exp_at(2, SEL_RDY,  1, "drop_ready_held");
      exp_at(3, SEL_RDY,  0, "drop_ready_fall");
      exp_at(3, SEL_ST,   0, "drop_to_pll_rst");
      exp_at(3, SEL_LOSS, (i < 255) ? i + 1 : 255, "loss_count");
      step(3);
      clk_locked = 1'b1;
      exp_at(13, SEL_RDY, 1, "relock_ready");
      step(13);
    end

    // Reset from RUN clears everything on the next cycle.
    reset = 1'b1;
    exp_at(1, SEL_PR,   1, "midrst_pll_reset");
    exp_at(1, SEL_RDY,  0, "midrst_clk_ready");
    exp_at(1, SEL_LOSS, 0, "midrst_loss");
    exp_at(1, SEL_ST,   0, "midrst_state");
    step(2);
    reset = 1'b0;

    // Lock glitch in STABLE: back to WAIT_LOCK, no new reset pulse.
    for (int d = 4; d <= 20; d++) exp_at(d, SEL_PR, 0, "glitch_no_pulse");
    exp_at(5,  SEL_ST,  2, "glitch_stable_entry");
    exp_at(8,  SEL_ST,  2, "glitch_still_stable");
    exp_at(9,  SEL_ST,  1, "glitch_back_wait");
    exp_at(11, SEL_ST,  1, "glitch_waiting");
    exp_at(12, SEL_ST,  2, "glitch_restable");
    exp_at(19, SEL_RDY, 0, "glitch_ready_early");
    exp_at(20, SEL_RDY, 1, "glitch_ready");
    exp_at(20, SEL_FAIL, 0, "glitch_no_fail");
    step(6);
    clk_locked = 1'b0;
    step(3);
    clk_locked = 1'b1;
    step(11);

    // Drop and hold lock low: 3 pulses of 4 cycles with 20-cycle gaps,
    // then FAIL with pll_reset held high.
    clk_locked = 1'b0;
    exp_at(3, SEL_LOSS, 1, "hold_low_loss");
    for (int d = 3; d <= 80; d++) begin
      exp_at(d, SEL_PR, ((d >= 3 && d <= 6) || (d >= 27 && d <= 30) ||
                         (d >= 51 && d <= 54) || d >= 75) ? 1 : 0, "retry_pll_reset");
      exp_at(d, SEL_FAIL, (d >= 75) ? 1 : 0, "retry_pll_fail");
    end
    exp_at(74, SEL_ST, 1, "last_wait_lock");
    exp_at(75, SEL_ST, 4, "fail_state");
    exp_at(80, SEL_ST, 4, "fail_sticky");
    step(80);

    // Restart from FAIL, lock 5 cycles after pll_reset falls.
    restart_req = 1'b1;
    exp_at(1, SEL_ST,   0, "restart_state");
    exp_at(1, SEL_FAIL, 0, "restart_clears_fail");
    exp_at(1, SEL_PR,   1, "restart_pll_reset");
    exp_at(1, SEL_LOSS, 1, "restart_keeps_loss");
    step(1);
    restart_req = 1'b0;
    exp_at(3, SEL_PR, 1, "restart_pulse_hi");
    exp_at(4, SEL_PR, 0, "restart_pulse_lo");
    step(9);
    clk_locked = 1'b1;
    exp_at(10, SEL_RDY,  0, "restart_ready_early");
    exp_at(11, SEL_RDY,  1, "restart_ready");
    exp_at(11, SEL_FAIL, 0, "restart_no_fail");
    exp_at(11, SEL_LOSS, 1, "restart_loss_kept");
    step(11);

    // Restart in the same RUN cycle as a synchronized lock drop.
    clk_locked = 1'b0;
    step(2);
    exp_at(0, SEL_ST, 3, "combo_still_run");
    restart_req = 1'b1;
    exp_at(1, SEL_ST,   0, "combo_state");
    exp_at(1, SEL_RDY,  0, "combo_ready");
    exp_at(1, SEL_LOSS, 2, "combo_loss_inc");
    step(1);
    restart_req = 1'b0;
    step(3);

    // Drain the scoreboard with a bound.
    for (int i = 0; i < 100 && sbq.size() != 0; i++) step(1);
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending checks expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 27: cycles pll_reset is held high per attempt (1 us at 27 MHz); legal range 1..65535.
REQ-002 Parameter LOCK_TIMEOUT, default 27000: cycles allowed for lock after pll_reset release (1 ms); legal range 1..65535.
REQ-003 Parameter STABLE_CYCLES, default 2700: consecutive synchronized-lock cycles required before ready (100 us); legal range 1..65535.
REQ-004 Parameter MAX_RETRIES, default 3: lock-timeout retries before fail; legal range 0..15.
REQ-005 clk27mhz  input  1  sole clock, 27 MHz PLL reference.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 clk_locked  input  1  PLL lock, asynchronous to clk27mhz.
REQ-008 restart_req  input  1  single-cycle pulse requesting a full PLL re-lock.
REQ-009 pll_reset  output  1  drives the PLL reset/reset_p pins.
REQ-010 clk_ready  output  1  high only while the PLL output clock is stable; gates downstream USB core reset.
REQ-011 pll_fail  output  1  sticky; lock not achieved within MAX_RETRIES+1 attempts.
REQ-012 lock_loss_cnt  output  8  saturating count of lock drops seen in RUN.
REQ-013 state_o  output  3  current FSM state encoding, for debug.

Function
REQ-014 clk_locked SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value only (lock_s).
REQ-015 FSM states SHALL be PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
REQ-016 PLL_RST: pll_reset=1; a cycle counter SHALL run from 0; at RST_CYCLES-1 the FSM SHALL go to WAIT_LOCK and clear the counter.
REQ-017 WAIT_LOCK: pll_reset=0; lock_s=1 SHALL go to STABLE with the counter cleared; when the counter reaches LOCK_TIMEOUT-1 without lock, the FSM SHALL increment retry_cnt and go to PLL_RST, or go to FAIL if retry_cnt already equals MAX_RETRIES.
REQ-018 STABLE: lock_s=0 SHALL return to WAIT_LOCK with the counter cleared, without consuming a retry; when the counter reaches STABLE_CYCLES-1 with lock_s=1, the FSM SHALL go to RUN and clear retry_cnt.
REQ-019 RUN: clk_ready=1; lock_s=0 SHALL increment lock_loss_cnt, saturating at 255, and go to PLL_RST.
REQ-020 FAIL: pll_reset=1, clk_ready=0, pll_fail=1; the FSM SHALL stay in FAIL until reset or restart_req.
REQ-021 restart_req in any state SHALL go to PLL_RST next cycle with the counter and retry_cnt cleared and pll_fail cleared; lock_loss_cnt SHALL be kept.
REQ-022 restart_req and lock drop in the same RUN cycle SHALL be treated as restart only; lock_loss_cnt SHALL still increment.
REQ-023 clk_ready SHALL be registered and equal (state==RUN) with no combinational path from clk_locked.
REQ-024 The shared counter SHALL be 16 bits and SHALL never wrap within any state.
REQ-025 Worst-case latency from lock_s rising in WAIT_LOCK to clk_ready=1 SHALL be STABLE_CYCLES+1 cycles.

Reset
REQ-026 While reset=1: state=PLL_RST, counter=0, retry_cnt=0, pll_reset=1, clk_ready=0, pll_fail=0, lock_loss_cnt=0, synchronizer flops=0.
REQ-027 Reset asserted mid-operation SHALL take priority over every other input in that cycle.

Structure
REQ-028 State encodings and the default timing constants SHALL live in the shared package pll_seq_pkg.
REQ-029 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, reusable for other cross-domain status bits.
REQ-030 pll_lock_sequencer SHALL NOT instantiate the PLL; the top level wires pll_reset and clk_locked to the existing PLL wrapper.

Verification (bench uses RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-031 Reset release, clk_locked rises 10 cycles after pll_reset falls -> clk_ready=1 exactly 2+8+1 cycles after the rise; pll_fail=0.
REQ-032 clk_locked held 0 -> exactly 3 pll_reset pulses of 4 cycles each, then state=FAIL, pll_fail=1, pll_reset=1 held.
REQ-033 Lock glitch low for 3 cycles during STABLE -> returns to WAIT_LOCK, no extra pll_reset pulse, retry_cnt unchanged.
REQ-034 In RUN, drop clk_locked 300 times -> lock_loss_cnt=255, clk_ready falls 3 cycles after each drop.
REQ-035 In FAIL, pulse restart_req, then lock 5 cycles after pll_reset falls -> pll_fail=0, clk_ready=1, lock_loss_cnt kept.
REQ-036 Assert reset in RUN -> next cycle pll_reset=1, clk_ready=0, lock_loss_cnt=0.
